// File: rtl/subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default operand width.
package subtractor_pkg;

  localparam int SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/full_subtractor_1bit.sv
// Single-bit full subtractor cell: d = a - b - bin, bout set when the subtraction underflows.
// Purely combinational; no latency and no flow control.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial A - B, LSB first, one bit per cycle; Done arrives WIDTH+1 cycles after the Start edge.
// Start is only honoured in IDLE (no queueing); SUBTRACTOR_SERIAL_SAT_EN clamps underflowing results to 0.
module subtractor_serial
  import subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             br;
  logic             d_bit;
  logic             bout;

  full_subtractor_1bit u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (bout)
  );

  assign Busy = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      br      <= 1'b0;
      Done    <= 1'b0;
      Diff    <= '0;
      Borrow  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a_sh    <= A;
            b_sh    <= B;
            br      <= 1'b0;
            cnt     <= '0;
            diff_sh <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          diff_sh <= {d_bit, diff_sh[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          br      <= bout;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          Done   <= 1'b1;
          Borrow <= br;
`ifdef SUBTRACTOR_SERIAL_SAT_EN
          Diff   <= br ? '0 : diff_sh;
`else
          Diff   <= diff_sh;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_serial.sv
// Randomised and directed checks of subtractor_serial against an arithmetic reference model.
module tb_subtractor_serial;

  localparam int W = 8;

  logic         Clk;
  logic         Rst_n;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Diff;
  logic         Borrow;

  int tot = 0;
  int bad = 0;

  subtractor_serial #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .Diff   (Diff),
    .Borrow (Borrow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: unsigned subtraction with plain integer arithmetic; result is {borrow, diff}.
  function automatic logic [W:0] ref_sub(input int a, input int b);
    int   r;
    logic bo;
    bo = (a < b);
    r  = a - b;
    if (r < 0) r = r + (1 << W);
`ifdef SUBTRACTOR_SERIAL_SAT_EN
    if (bo) r = 0;
`endif
    return {bo, r[W-1:0]};
  endfunction

  // Pulses Start for one cycle and observes the response; lat counts edges from the Start edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_n,
                       output logic [W-1:0] d, output logic bo, output logic done_next);
    Start = 1'b1; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    A = $urandom_range(0, 255); B = $urandom_range(0, 255);
    lat = 0;
    busy_n = (Busy === 1'b1) ? 1 : 0;
    while (Done !== 1'b1 && lat < 40) begin
      @(negedge Clk);
      lat++;
      if (Busy === 1'b1) busy_n++;
    end
    d  = Diff;
    bo = Borrow;
    @(negedge Clk);
    done_next = Done;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    tot++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    tot++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Done); end
    tot++; if (Diff !== '0) begin bad++; $display("FAIL reset_diff got=%0d want=0", Diff); end
    tot++; if (Borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b want=0", Borrow); end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{8'd200, 8'd55, 8'hAA, 8'h00, 8'd10, 8'hFF};
    logic [W-1:0] tb [6] = '{8'd55, 8'd200, 8'hAA, 8'h01, 8'd3, 8'h00};
    for (int i = 0; i < 6; i++) begin
      int lat, bn; logic [W-1:0] d; logic bo, dn; logic [W:0] exp;
      exp = ref_sub(int'(ta[i]), int'(tb[i]));
      do_op(ta[i], tb[i], lat, bn, d, bo, dn);
      tot++; if (lat != W + 1) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=%0d", i, lat, W + 1); end
      tot++; if (bn != W + 1) begin bad++; $display("FAIL dir_busy_cycles[%0d] got=%0d want=%0d", i, bn, W + 1); end
      tot++; if (d !== exp[W-1:0]) begin bad++; $display("FAIL dir_diff[%0d] got=%0d want=%0d", i, d, exp[W-1:0]); end
      tot++; if (bo !== exp[W]) begin bad++; $display("FAIL dir_borrow[%0d] got=%b want=%b", i, bo, exp[W]); end
      tot++; if (dn !== 1'b0) begin bad++; $display("FAIL dir_done_pulse[%0d] got=%b want=0", i, dn); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int lat, bn; logic [W-1:0] a, b, d; logic bo, dn; logic [W:0] exp;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      exp = ref_sub(int'(a), int'(b));
      do_op(a, b, lat, bn, d, bo, dn);
      tot++; if (lat != W + 1) begin bad++; $display("FAIL rnd_latency a=%0d b=%0d got=%0d want=%0d", a, b, lat, W + 1); end
      tot++; if ({bo, d} !== exp) begin bad++; $display("FAIL rnd_result a=%0d b=%0d got=%b/%0d want=%b/%0d", a, b, bo, d, exp[W], exp[W-1:0]); end
      if ($urandom_range(0, 1) == 1) @(negedge Clk);
    end
  endtask

  task automatic test_ignore_start();
    int dones; logic [W-1:0] d; logic bo; logic [W:0] exp;
    int lat, bn; logic dn;
    dones = 0; d = '0; bo = 1'b0;
    Start = 1'b1; A = 8'd10; B = 8'd3;
    @(negedge Clk);
    Start = 1'b0; A = 8'd1; B = 8'd2;
    repeat (2) @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin dones++; d = Diff; bo = Borrow; end
    end
    exp = ref_sub(10, 3);
    tot++; if (dones != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", dones); end
    tot++; if ({bo, d} !== exp) begin bad++; $display("FAIL ign_result got=%b/%0d want=%b/%0d", bo, d, exp[W], exp[W-1:0]); end
    exp = ref_sub(1, 2);
    do_op(8'd1, 8'd2, lat, bn, d, bo, dn);
    tot++; if ({bo, d} !== exp) begin bad++; $display("FAIL ign_second got=%b/%0d want=%b/%0d", bo, d, exp[W], exp[W-1:0]); end
  endtask

  task automatic test_reset_mid();
    int dones, lat, bn; logic [W-1:0] d; logic bo, dn; logic [W:0] exp;
    dones = 0;
    Start = 1'b1; A = 8'd77; B = 8'd33;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    tot++; if (Busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", Busy); end
    Rst_n = 1'b0;
    #1;
    tot++; if ({Busy, Done, Borrow} !== 3'b000) begin bad++; $display("FAIL mid_ctl_cleared got=%b want=000", {Busy, Done, Borrow}); end
    tot++; if (Diff !== '0) begin bad++; $display("FAIL mid_diff_cleared got=%0d want=0", Diff); end
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge Clk);
      if (Done === 1'b1) dones++;
    end
    tot++; if (dones != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", dones); end
    exp = ref_sub(77, 33);
    do_op(8'd77, 8'd33, lat, bn, d, bo, dn);
    tot++; if (lat != W + 1) begin bad++; $display("FAIL mid_after_latency got=%0d want=%0d", lat, W + 1); end
    tot++; if ({bo, d} !== exp) begin bad++; $display("FAIL mid_after_result got=%b/%0d want=%b/%0d", bo, d, exp[W], exp[W-1:0]); end
  endtask

  task automatic test_back_to_back();
    int done_at[$]; int bad_vals; logic [W:0] exp;
    bad_vals = 0;
    exp = ref_sub(100, 1);
    Start = 1'b1; A = 8'd100; B = 8'd1;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        done_at.push_back(i);
        if ({Borrow, Diff} !== exp) bad_vals++;
      end
    end
    Start = 1'b0;
    repeat (12) @(negedge Clk);
    tot++; if (done_at.size() != 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", done_at.size()); end
    tot++; if (done_at.size() > 0 && done_at[0] != W + 1) begin bad++; $display("FAIL b2b_first_done got=%0d want=%0d", done_at[0], W + 1); end
    for (int i = 1; i < done_at.size(); i++) begin
      tot++; if (done_at[i] - done_at[i-1] != W + 2) begin bad++; $display("FAIL b2b_period[%0d] got=%0d want=%0d", i, done_at[i] - done_at[i-1], W + 2); end
    end
    tot++; if (bad_vals != 0) begin bad++; $display("FAIL b2b_values got=%0d wrong results want=0", bad_vals); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
